// File: rtl/sop_glitch_filter_counter.sv
// Deglitch filter for the two sum-of-products outputs of a 7458-style gate block.
// Each lane samples its input, filters it for stability, flags filtered rises and counts them.

module sop_gf_lane #(
  parameter int FILTER_LEN = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             din,
  output logic             filt,
  output logic             rise,
  output logic [CNT_W-1:0] count,
  output logic             sat
);
  localparam int RUN_W = $clog2(FILTER_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILTER_LEN - 1);

  logic             in_q;
  logic [RUN_W-1:0] run;
  logic             filt_q, filt_next, rise_q, rise_next;
  logic [CNT_W-1:0] cnt_q;

  // The filtered level flips on the same edge the stability run completes.
  always_comb begin
    filt_next = filt_q;
    if ((in_q != filt_q) && (run == RUN_LAST)) filt_next = in_q;
    rise_next = filt_next & ~filt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_q   <= 1'b0;
      run    <= '0;
      filt_q <= 1'b0;
      rise_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      in_q   <= din;
      filt_q <= filt_next;
      rise_q <= rise_next;
      if (in_q == filt_q)       run <= '0;
      else if (run == RUN_LAST) run <= '0;
      else                      run <= run + 1'b1;
      // Clear wins over a coincident rise; the rise pulse itself is unaffected.
      if (clear)                        cnt_q <= '0;
      else if (rise_next && !(&cnt_q))  cnt_q <= cnt_q + 1'b1;
    end
  end

  assign filt  = filt_q;
  assign rise  = rise_q;
  assign count = cnt_q;
  assign sat   = &cnt_q;
endmodule

module sop_glitch_filter_counter #(
  parameter int FILTER_LEN = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             p1y,
  input  logic             p2y,
  output logic             p1f,
  output logic             p2f,
  output logic             p1_rise,
  output logic             p2_rise,
  output logic [CNT_W-1:0] p1_count,
  output logic [CNT_W-1:0] p2_count,
  output logic             p1_sat,
  output logic             p2_sat
);
  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0]            din, filt, rise, sat;
  logic [NUM_LANES-1:0][CNT_W-1:0] count;

  assign din = {p2y, p1y};

  generate
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      sop_gf_lane #(.FILTER_LEN(FILTER_LEN), .CNT_W(CNT_W)) u_lane (
        .clk  (clk),
        .reset(reset),
        .clear(clear),
        .din  (din[l]),
        .filt (filt[l]),
        .rise (rise[l]),
        .count(count[l]),
        .sat  (sat[l])
      );
    end
  endgenerate

  assign p1f      = filt[0];
  assign p2f      = filt[1];
  assign p1_rise  = rise[0];
  assign p2_rise  = rise[1];
  assign p1_count = count[0];
  assign p2_count = count[1];
  assign p1_sat   = sat[0];
  assign p2_sat   = sat[1];
endmodule

// File: tb/tb_sop_glitch_filter_counter.sv
// Directed and model-compared checks of the SOP glitch filter / rise counter.
// Three instances share stimulus: defaults, a 3-bit counter, and a longer filter.

module tb_sop_glitch_filter_counter;
  logic clk = 1'b0;
  logic reset = 1'b0, clear = 1'b0, p1y = 1'b0, p2y = 1'b0;
  int   errors = 0, checks = 0;

  always #5 clk = ~clk;

  logic a_f1, a_f2, a_r1, a_r2, a_s1, a_s2;
  logic [7:0] a_c1, a_c2;
  logic b_f1, b_f2, b_r1, b_r2, b_s1, b_s2;
  logic [2:0] b_c1, b_c2;
  logic c_f1, c_f2, c_r1, c_r2, c_s1, c_s2;
  logic [7:0] c_c1, c_c2;

  sop_glitch_filter_counter dut_a (
    .clk(clk), .reset(reset), .clear(clear), .p1y(p1y), .p2y(p2y),
    .p1f(a_f1), .p2f(a_f2), .p1_rise(a_r1), .p2_rise(a_r2),
    .p1_count(a_c1), .p2_count(a_c2), .p1_sat(a_s1), .p2_sat(a_s2));

  sop_glitch_filter_counter #(.FILTER_LEN(2), .CNT_W(3)) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .p1y(p1y), .p2y(p2y),
    .p1f(b_f1), .p2f(b_f2), .p1_rise(b_r1), .p2_rise(b_r2),
    .p1_count(b_c1), .p2_count(b_c2), .p1_sat(b_s1), .p2_sat(b_s2));

  sop_glitch_filter_counter #(.FILTER_LEN(3), .CNT_W(8)) dut_c (
    .clk(clk), .reset(reset), .clear(clear), .p1y(p1y), .p2y(p2y),
    .p1f(c_f1), .p2f(c_f2), .p1_rise(c_r1), .p2_rise(c_r2),
    .p1_count(c_c1), .p2_count(c_c2), .p1_sat(c_s1), .p2_sat(c_s2));

  // Cycle-level reference model, one state per instance and channel.
  typedef struct {
    logic in_q;
    int   run;
    logic filt;
    logic rise;
    int   cnt;
  } ch_t;

  localparam int FLS [3] = '{2, 2, 3};
  localparam int CMX [3] = '{255, 7, 255};
  ch_t ms [3][2];

  function automatic ch_t step(ch_t s, logic d, logic rst, logic clr, int fl, int cmax);
    ch_t  n;
    logic fn;
    n = s;
    if (rst) begin
      n.in_q = 1'b0; n.run = 0; n.filt = 1'b0; n.rise = 1'b0; n.cnt = 0;
      return n;
    end
    n.in_q = d;
    fn = s.filt;
    if (s.in_q == s.filt) n.run = 0;
    else if (s.run == fl - 1) begin fn = s.in_q; n.run = 0; end
    else n.run = s.run + 1;
    n.filt = fn;
    n.rise = fn & ~s.filt;
    if (clr) n.cnt = 0;
    else if (n.rise && s.cnt != cmax) n.cnt = s.cnt + 1;
    return n;
  endfunction

  always @(posedge clk)
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 2; j++)
        ms[i][j] <= step(ms[i][j], (j == 0) ? p1y : p2y, reset, clear, FLS[i], CMX[i]);

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    logic [3:0] ef;
    reset = 1'b1; clear = 1'b0; p1y = 1'b1; p2y = 1'b1;
    tick(2);
    checks++;
    if ({a_f1, a_f2, a_r1, a_r2, a_s1, a_s2} !== 6'b0 || a_c1 !== 8'd0 || a_c2 !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: got f=%b%b r=%b%b s=%b%b c=%0d/%0d want all 0",
               a_f1, a_f2, a_r1, a_r2, a_s1, a_s2, a_c1, a_c2);
    end
    reset = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      tick();
      // Filtered level appears after the 3rd edge; pulse only then.
      ef = {(t >= 3), (t >= 3), (t == 3), (t == 3)};
      checks++;
      if ({a_f1, a_f2, a_r1, a_r2} !== ef || a_c1 !== ((t >= 3) ? 8'd1 : 8'd0)) begin
        errors++;
        $display("FAIL release_t%0d: got f=%b%b r=%b%b c1=%0d want %b c1=%0d",
                 t, a_f1, a_f2, a_r1, a_r2, a_c1, ef, (t >= 3));
      end
    end
    p1y = 1'b0; p2y = 1'b0;
    tick(4);
  endtask

  task automatic test_glitch;
    logic ef, er;
    logic [7:0] ec;
    clear = 1'b1; tick(); clear = 1'b0;
    p2y = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      tick();
      if (t == 1) p2y = 1'b0;
      checks++;
      if (a_f2 !== 1'b0 || a_r2 !== 1'b0 || a_c2 !== 8'd0) begin
        errors++;
        $display("FAIL glitch_reject_t%0d: got f=%b r=%b c=%0d want 0/0/0", t, a_f2, a_r2, a_c2);
      end
    end
    p2y = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (t == 2) p2y = 1'b0;
      ef = (t == 3 || t == 4);
      er = (t == 3);
      ec = (t >= 3) ? 8'd1 : 8'd0;
      checks++;
      if (a_f2 !== ef || a_r2 !== er || a_c2 !== ec) begin
        errors++;
        $display("FAIL glitch_accept_t%0d: got f=%b r=%b c=%0d want %b/%b/%0d",
                 t, a_f2, a_r2, a_c2, ef, er, ec);
      end
    end
  endtask

  task automatic pulse_p1;
    p1y = 1'b1; tick(4);
    p1y = 1'b0; tick(4);
  endtask

  task automatic test_saturation;
    int rises = 0;
    int ec;
    clear = 1'b1; tick(); clear = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      p1y = 1'b1;
      for (int t = 0; t < 8; t++) begin
        tick();
        if (t == 3) p1y = 1'b0;
        if (b_r1 === 1'b1) rises++;
      end
      ec = (k < 7) ? k : 7;
      checks++;
      if (b_c1 !== 3'(ec) || b_s1 !== (k >= 7)) begin
        errors++;
        $display("FAIL sat_pulse%0d: got c=%0d sat=%b want c=%0d sat=%b", k, b_c1, b_s1, ec, (k >= 7));
      end
    end
    checks++;
    if (rises != 9) begin
      errors++;
      $display("FAIL sat_rise_count: got %0d pulses want 9", rises);
    end
  endtask

  task automatic test_clear_collision;
    clear = 1'b1; tick(); clear = 1'b0;
    repeat (5) pulse_p1();
    checks++;
    if (b_c1 !== 3'd5) begin
      errors++;
      $display("FAIL clr_pre: got c=%0d want 5", b_c1);
    end
    p1y = 1'b1;
    tick(2);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (b_c1 !== 3'd0 || b_r1 !== 1'b1 || b_f1 !== 1'b1) begin
      errors++;
      $display("FAIL clr_collide: got c=%0d r=%b f=%b want 0/1/1", b_c1, b_r1, b_f1);
    end
    tick();
    p1y = 1'b0; tick(4);
    pulse_p1();
    checks++;
    if (b_c1 !== 3'd1) begin
      errors++;
      $display("FAIL clr_next_rise: got c=%0d want 1", b_c1);
    end
  endtask

  task automatic test_reset_midfilter;
    p1y = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      tick();
      checks++;
      if (a_f1 !== (t == 3) || a_r1 !== (t == 3)) begin
        errors++;
        $display("FAIL midreset_t%0d: got f=%b r=%b want %b", t, a_f1, a_r1, (t == 3));
      end
    end
    p1y = 1'b0; tick(4);
  endtask

  task automatic test_random;
    logic [5:0] g;
    int hold = 0;
    int bad = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (hold == 0) begin
        g    = 6'($urandom);
        p1y  = (g[0] & g[1] & g[2]) | (g[3] & g[4] & g[5]);
        p2y  = (g[0] & g[1]) | (g[2] & g[3]);
        hold = $urandom_range(0, 4);
      end else hold--;
      clear = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 79) == 0);
      tick();
      checks++;
      if ({a_f1, a_f2, a_r1, a_r2} !== {ms[0][0].filt, ms[0][1].filt, ms[0][0].rise, ms[0][1].rise} ||
          a_c1 !== 8'(ms[0][0].cnt) || a_c2 !== 8'(ms[0][1].cnt) ||
          a_s1 !== (ms[0][0].cnt == 255) || a_s2 !== (ms[0][1].cnt == 255) ||
          {b_f1, b_f2, b_r1, b_r2} !== {ms[1][0].filt, ms[1][1].filt, ms[1][0].rise, ms[1][1].rise} ||
          b_c1 !== 3'(ms[1][0].cnt) || b_c2 !== 3'(ms[1][1].cnt) ||
          b_s1 !== (ms[1][0].cnt == 7) || b_s2 !== (ms[1][1].cnt == 7) ||
          {c_f1, c_f2, c_r1, c_r2} !== {ms[2][0].filt, ms[2][1].filt, ms[2][0].rise, ms[2][1].rise} ||
          c_c1 !== 8'(ms[2][0].cnt) || c_c2 !== 8'(ms[2][1].cnt) ||
          c_s1 !== (ms[2][0].cnt == 255) || c_s2 !== (ms[2][1].cnt == 255)) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_cyc%0d: a=%b%b%b%b c=%0d/%0d b=%b%b%b%b c=%0d/%0d c=%b%b%b%b c=%0d/%0d model a f=%b%b c=%0d/%0d",
                   cyc, a_f1, a_f2, a_r1, a_r2, a_c1, a_c2, b_f1, b_f2, b_r1, b_r2, b_c1, b_c2,
                   c_f1, c_f2, c_r1, c_r2, c_c1, c_c2,
                   ms[0][0].filt, ms[0][1].filt, ms[0][0].cnt, ms[0][1].cnt);
      end
    end
    clear = 1'b0; reset = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_glitch();
    test_saturation();
    test_clear_collision();
    test_reset_midfilter();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
